// File: rtl/cache_access_controller.sv
`timescale 1ns/1ps
// cache_access_controller
// Sequences one CPU request at a time through a direct-mapped cache and a
// variable-latency main memory. Reads do a lookup and refill on a miss.
// Writes go to the cache and then to memory (write-through, write-allocate).
// A memory timeout ends the request with an error. Read hit and miss
// statistics are kept in saturating counters.
//
// Handshake: the controller accepts a request when cpu_req is high at a rising
// edge while cpu_ready is high. It reports completion with a single-cycle
// cpu_done pulse. cpu_rdata and cpu_err are meaningful only while cpu_done is
// high. On the memory side, mem_req is held until the one-cycle mem_ack or the
// timeout, whichever comes first.
module cache_access_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,
    output logic                  c_rd_en,
    output logic                  c_wr_en,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [DATA_WIDTH-1:0] c_wdata,
    input  logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  c_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_CHECK  = 3'd2,
        S_MEM_RD = 3'd3,
        S_FILL   = 3'd4,
        S_CWR    = 3'd5,
        S_MEM_WR = 3'd6,
        S_RESP   = 3'd7
    } state_t;

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    we_q;
    logic                    err_q;
    logic [TW-1:0]           wait_q;
    logic [CNT_WIDTH-1:0]    hit_q;
    logic [CNT_WIDTH-1:0]    miss_q;

    // The last allowed wait cycle has arrived and memory still has not answered.
    logic timed_out;
    assign timed_out = (wait_q == WAIT_LAST) && !mem_ack;

    assign hit_cnt     = hit_q;
    assign miss_cnt    = miss_q;
    assign dbg_state_o = state_q;

    // State register; reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    state_d = cpu_we ? S_CWR : S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK:  state_d = c_hit ? S_RESP : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ack) begin
                    state_d = S_FILL;
                end else if (timed_out) begin
                    state_d = S_RESP;
                end
            end
            S_FILL:   state_d = S_RESP;
            S_CWR:    state_d = S_MEM_WR;
            S_MEM_WR: begin
                if (mem_ack || timed_out) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode; every output depends only on registered state and data.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_done  = 1'b0;
        cpu_rdata = '0;
        cpu_err   = 1'b0;
        c_rd_en   = 1'b0;
        c_wr_en   = 1'b0;
        c_addr    = '0;
        c_wdata   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: cpu_ready = 1'b1;
            S_LOOKUP: begin
                c_rd_en = 1'b1;
                c_addr  = addr_q;
            end
            S_FILL: begin
                c_wr_en = 1'b1;
                c_addr  = addr_q;
                c_wdata = rdata_q;
            end
            S_CWR: begin
                c_wr_en = 1'b1;
                c_addr  = addr_q;
                c_wdata = wdata_q;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            S_RESP: begin
                cpu_done  = 1'b1;
                cpu_err   = err_q;
                // Writes and timeouts return zero instead of stale captured data.
                cpu_rdata = (we_q || err_q) ? '0 : rdata_q;
            end
            default: ;
        endcase
    end

    // Request latch, read-data capture and the error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        err_q   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (c_hit) begin
                        rdata_q <= c_rdata;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end
                end
                S_MEM_WR: begin
                    if (timed_out) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory wait counter: zero on entry to a memory state, +1 per cycle there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else if (state_q == S_MEM_RD || state_q == S_MEM_WR) begin
            wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    // Read hit/miss statistics, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == S_CHECK) begin
            if (c_hit) begin
                if (hit_q != '1) begin
                    hit_q <= hit_q + 1'b1;
                end
            end else begin
                if (miss_q != '1) begin
                    miss_q <= miss_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_access_controller.sv
`timescale 1ns/1ps
// Testbench for cache_access_controller with a behavioural direct-mapped cache
// (16 lines, index = addr[3:0]) and a memory whose ack latency is set per request.
module tb_cache_access_controller;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 8;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready, cpu_done, cpu_err;
  logic [DW-1:0] cpu_rdata;
  logic          c_rd_en, c_wr_en;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata = '0;
  logic          c_hit = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] hit_cnt, miss_cnt;
  logic [2:0]    dbg_state;

  cache_access_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .c_rd_en(c_rd_en), .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_hit(c_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int acc_edge = 0;
  int done_cnt = 0;
  int mreq_cycles = 0;
  int cwr_cycles = 0;
  logic mwr_seen = 1'b0;
  logic [DW-1:0] mwr_data = '0;
  int mem_lat = 2;   // 0 = never ack; otherwise ack in the mem_lat-th mem_req cycle (>=2)

  // expected entry: {latency[7:0], err, rdata[7:0]}
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- cache model ----------------
  logic [DW-1:0]   cache_data[16];
  logic [AW-5:0]   cache_tag[16];
  logic [15:0]     cache_valid = '0;

  always @(posedge clk) begin
    if (c_wr_en) begin
      cache_data[c_addr[3:0]]  <= c_wdata;
      cache_tag[c_addr[3:0]]   <= c_addr[AW-1:4];
      cache_valid[c_addr[3:0]] <= 1'b1;
    end
    if (c_rd_en) begin
      c_hit   <= cache_valid[c_addr[3:0]] && (cache_tag[c_addr[3:0]] == c_addr[AW-1:4]);
      c_rdata <= cache_valid[c_addr[3:0]] ? cache_data[c_addr[3:0]] : '0;
    end
  end

  // ---------------- memory model ----------------
  logic [255:0]  mem_written = '0;
  logic [DW-1:0] mem_wr_val[256];
  int mem_cnt = 0;

  function automatic logic [DW-1:0] mem_val(input logic [7:0] a);
    if (mem_written[a]) return mem_wr_val[a];
    if (a == 8'h10) return 8'hA5;
    return a ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      mem_ack <= 1'b0;
      mem_cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (mem_lat != 0 && mem_cnt == mem_lat - 2) begin
          mem_ack <= 1'b1;
          mem_cnt <= 0;
          if (mem_we) begin
            mem_written[mem_addr[7:0]] <= 1'b1;
            mem_wr_val[mem_addr[7:0]]  <= mem_wdata;
            mem_rdata <= '0;
          end else begin
            mem_rdata <= mem_val(mem_addr[7:0]);
          end
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else if (!mem_req) begin
        mem_cnt <= 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [16:0] e;
    if (mem_req) mreq_cycles++;
    if (mem_req && mem_we) begin
      mwr_seen = 1'b1;
      mwr_data = mem_wdata;
    end
    if (c_wr_en) cwr_cycles++;
    if (cpu_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(cpu_done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_rdata", 32'(cpu_rdata), 32'(e[7:0]));
        check("done_err", 32'(cpu_err), 32'(e[8]));
        check("done_latency", 32'(edge_n + 1 - acc_edge), 32'(e[16:9]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_lat);
    int n;
    logic [7:0] lat8;
    n = 0;
    while (!cpu_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_issue", 32'(cpu_ready), 32'd1);
    mreq_cycles = 0;
    cwr_cycles  = 0;
    mwr_seen    = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    lat8 = exp_lat[7:0];
    exp_q.push_back({lat8, exp_err, exp_rd});
    @(posedge clk); #1;
    acc_edge = edge_n;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_lat);
    int start;
    int n;
    start = done_cnt;
    issue(we, addr, wd, exp_rd, exp_err, exp_lat);
    n = 0;
    while (done_cnt == start && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == start) begin
      check("done_timeout", 32'(done_cnt), 32'(start + 1));
      exp_q.delete();
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int d0;
    reset = 1'b0;
    #23;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_cnts", 32'({hit_cnt, miss_cnt}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // cold read miss, ack in 4th mem_req cycle -> done in cycle 5+3
    mem_lat = 4;
    txn(1'b0, 32'h10, 8'h00, 8'hA5, 1'b0, 8);
    check("t1_mreq_cycles", 32'(mreq_cycles), 32'd4);
    check("t1_fill_cycles", 32'(cwr_cycles), 32'd1);
    check("t1_miss", 32'(miss_cnt), 32'd1);
    check("t1_hit", 32'(hit_cnt), 32'd0);

    // repeat read hits
    txn(1'b0, 32'h10, 8'h00, 8'hA5, 1'b0, 3);
    check("t2_mreq_cycles", 32'(mreq_cycles), 32'd0);
    check("t2_hit", 32'(hit_cnt), 32'd1);

    // write-through then read back
    mem_lat = 3;
    txn(1'b1, 32'h18, 8'h3C, 8'h00, 1'b0, 5);
    check("t3_cwr_cycles", 32'(cwr_cycles), 32'd1);
    check("t3_mem_we_seen", 32'(mwr_seen), 32'd1);
    check("t3_mem_wdata", 32'(mwr_data), 32'h3C);
    check("t3_mreq_cycles", 32'(mreq_cycles), 32'd3);
    txn(1'b0, 32'h18, 8'h00, 8'h3C, 1'b0, 3);
    check("t3_hit", 32'(hit_cnt), 32'd2);
    check("t3_miss", 32'(miss_cnt), 32'd1);

    // conflicting index: both miss
    mem_lat = 2;
    txn(1'b0, 32'h30, 8'h00, 8'h6A, 1'b0, 6);
    txn(1'b0, 32'h10, 8'h00, 8'hA5, 1'b0, 6);
    check("t4_miss", 32'(miss_cnt), 32'd3);
    check("t4_hit", 32'(hit_cnt), 32'd2);

    // memory never acks -> timeout after 8 cycles of mem_req
    mem_lat = 0;
    txn(1'b0, 32'h44, 8'h00, 8'h00, 1'b1, 11);
    check("t5_mreq_cycles", 32'(mreq_cycles), 32'd8);
    check("t5_no_fill", 32'(cwr_cycles), 32'd0);
    check("t5_miss", 32'(miss_cnt), 32'd4);
    mem_lat = 2;
    txn(1'b0, 32'h44, 8'h00, 8'h1E, 1'b0, 6);
    check("t5_reread_miss", 32'(miss_cnt), 32'd5);

    // reset while waiting in MEM_RD
    mem_lat = 0;
    issue(1'b0, 32'h5C, 8'h00, 8'h00, 1'b0, 0);
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_mem_req_up", 32'(mem_req), 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("t6_mem_req_drop", 32'(mem_req), 32'd0);
    check("t6_ready_in_reset", 32'(cpu_ready), 32'd1);
    check("t6_cnts_cleared", 32'({hit_cnt, miss_cnt}), 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_done", 32'(done_cnt), 32'(d0));
    check("t6_ready_after", 32'(cpu_ready), 32'd1);
    check("t6_state_idle", 32'(dbg_state), 32'd0);

    // hit counter saturation at all-ones
    mem_lat = 2;
    for (int i = 0; i < 15; i++) txn(1'b0, 32'h10, 8'h00, 8'hA5, 1'b0, 3);
    check("t7_hit_full", 32'(hit_cnt), 32'hF);
    for (int i = 0; i < 2; i++) txn(1'b0, 32'h10, 8'h00, 8'hA5, 1'b0, 3);
    check("t7_hit_saturated", 32'(hit_cnt), 32'hF);
    check("t7_miss_zero", 32'(miss_cnt), 32'd0);

    repeat (3) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_access_controller.md
Name: cache_access_controller

Overview:
- Sequencing FSM between a single CPU-side requester, the direct-mapped cache system and a variable-latency main memory.
- Reads: cache lookup, refill from memory on a miss, then return the data.
- Writes: write-through with write-allocate (cache write, then memory write).
- Holds saturating hit/miss statistics counters and a memory-timeout error path.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 8, data word width
TIMEOUT, 64, max cycles to wait for mem_ack before aborting (>=2)
CNT_WIDTH, 16, width of hit/miss counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  request strobe, sampled only when cpu_ready=1
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_WIDTH  request address
cpu_wdata  in  DATA_WIDTH  write data
cpu_ready  out  1  controller idle, can accept request
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_done
cpu_err  out  1  completion was a memory timeout, valid with cpu_done
c_rd_en  out  1  cache read enable
c_wr_en  out  1  cache write enable (updates tag/valid and data)
c_addr  out  ADDR_WIDTH  cache address
c_wdata  out  DATA_WIDTH  cache write data
c_rdata  in  DATA_WIDTH  cache read data
c_hit  in  1  cache hit flag
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  memory write
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  memory completion (one cycle), carries mem_rdata for reads
mem_rdata  in  DATA_WIDTH  memory read data
hit_cnt  out  CNT_WIDTH  read hits, saturating
miss_cnt  out  CNT_WIDTH  read misses, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0 except cpu_ready=1; counters 0; latched addr/data/rdata 0.
- IDLE:
  - cpu_ready=1.
  - On cpu_req=1: latch addr/we/wdata.
  - Read -> LOOKUP; write -> CWR.
  - cpu_ready=0 in every other state; cpu_req ignored there.
- LOOKUP: c_rd_en=1, c_addr=latched addr for one cycle -> CHECK.
- CHECK: sample c_hit and c_rdata (the cache presents them one cycle after c_rd_en).
  - Hit: capture c_rdata, hit_cnt+1 -> RESP.
  - Miss: miss_cnt+1 -> MEM_RD.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ack: capture mem_rdata -> FILL.
  - Timeout -> RESP with err.
- FILL: c_wr_en=1, c_addr=latched addr, c_wdata=captured data for one cycle -> RESP.
- CWR: c_wr_en=1 with latched addr/wdata for one cycle -> MEM_WR.
- MEM_WR: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched.
  - On mem_ack -> RESP.
  - Timeout -> RESP with err. The cache keeps the new data.
- RESP: cpu_done=1 for exactly one cycle.
  - cpu_rdata=captured data for reads; 0 for writes and errors.
  - cpu_err per path.
  - -> IDLE.
- Latency, counting the accept edge as cycle 0:
  - Read hit: cpu_done in cycle 3.
  - Read miss: mem_req rises in cycle 3. With ack in cycle 3+k, FILL is in cycle 4+k and cpu_done in cycle 5+k.
  - Write: CWR in cycle 1, mem_req from cycle 2. With ack in cycle 2+k, cpu_done is in cycle 3+k.
- Timeout:
  - A wait counter clears on entering MEM_RD/MEM_WR and increments each cycle without ack.
  - When the counter reaches TIMEOUT-1 with mem_ack=0, mem_req drops next cycle and the FSM enters RESP with cpu_err=1.
  - mem_ack on the same cycle as the timeout has priority (success).
- mem_ack outside MEM_RD/MEM_WR is ignored.
- Counters:
  - Reads only; writes are not counted.
  - Saturate at all-ones (no wrap).
  - Cleared only by reset.
- Reset mid-operation: immediate return to IDLE.
  - mem_req, c_wr_en and cpu_done drop asynchronously.
  - No completion is reported for the aborted request.
- All outputs are registered or decoded from the registered state; no combinational path from cpu_* inputs to outputs.

Test Plan:
- Reset then read 0x10 on a cold cache, mem returns 0xA5 after 4 cycles -> mem_req high 4 cycles; FILL writes 0xA5; cpu_done with cpu_rdata=0xA5, cpu_err=0; miss_cnt=1, hit_cnt=0.
- Repeat read 0x10 -> no mem_req; cpu_done exactly 3 cycles after accept; rdata=0xA5; hit_cnt=1.
- Write 0x3C to 0x18, then read 0x18 -> c_wr_en then mem_req/mem_we=1 with data 0x3C; read hits with 0x3C.
- Conflicting read 0x30 (same index as 0x10), then read 0x10 -> both miss; miss_cnt increments twice.
- Read miss with mem_ack never asserted, TIMEOUT=8 -> mem_req high exactly 8 cycles; cpu_done with cpu_err=1 and rdata=0; no c_wr_en; the next read of that address misses again.
- Assert reset while in MEM_RD -> mem_req=0 immediately; cpu_ready=1 after release; no cpu_done; counters 0. Separately, force a counter to saturation and confirm it holds at all-ones.
